// File: rtl/sdram_refresh_ctrl.sv
// rtl/sdram_refresh_ctrl.sv - SDRAM auto-refresh controller
// tREFI tick generation, refresh debt tracking, and PRE-ALL + AREF burst sequencing.
module sdram_refresh_ctrl #(
  parameter int ASIZE     = 12,
  parameter int T_REFI    = 1560,
  parameter int T_RP      = 2,
  parameter int T_RFC     = 7,
  parameter int REF_BURST = 2,
  parameter int MAX_DEBT  = 8,
  parameter int URGENT_TH = 6
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             ref_en,
  input  logic             ref_ack,
  output logic             ref_req,
  output logic             ref_urgent,
  output logic             ref_busy,
  output logic             ref_done,
  output logic             ref_ovf,
  output logic [3:0]       debt,
  output logic             Cs_n,
  output logic             Ras_n,
  output logic             Cas_n,
  output logic             We_n,
  output logic [ASIZE-1:0] Sa
);

  localparam int TW   = (T_REFI > 1) ? $clog2(T_REFI) : 1;
  localparam int WMAX = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int CW   = $clog2(WMAX + 1);
  localparam int BW   = $clog2(REF_BURST + 1);

  localparam logic [3:0]       CMD_NOP  = 4'b0111;
  localparam logic [3:0]       CMD_PRE  = 4'b0010;
  localparam logic [3:0]       CMD_AREF = 4'b0001;
  localparam logic [3:0]       DEBT_MAX = 4'(MAX_DEBT);
  localparam logic [3:0]       DEBT_URG = 4'(URGENT_TH);
  localparam logic [ASIZE-1:0] SA_PALL  = ASIZE'(1024);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_PRE, S_TRP, S_AREF, S_TRFC, S_DONE
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic            tick;
  logic            aref_now;
  logic [CW-1:0]   wait_cnt;
  logic [BW-1:0]   n_ref;
  logic [BW-1:0]   issued;
  logic [BW-1:0]   burst_n;
  logic            more;
  logic [3:0]      cmd;

  assign tick       = ref_en && (timer == TW'(T_REFI - 1));
  assign aref_now   = (state == S_AREF);
  assign ref_urgent = (debt >= DEBT_URG);
  assign more       = (issued < n_ref);
  assign {Cs_n, Ras_n, Cas_n, We_n} = cmd;

  always_comb begin
    burst_n = BW'(REF_BURST);
    if (32'(debt) < REF_BURST) burst_n = BW'(debt);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      timer <= '0;
    end else if (!ref_en || tick) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // A tick and an AREF in the same cycle cancel, so debt only moves on one of them alone.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      debt    <= '0;
      ref_ovf <= 1'b0;
    end else begin
      if (tick && debt == DEBT_MAX) ref_ovf <= 1'b1;
      if (!ref_en) begin
        debt <= '0;
      end else if (tick && !aref_now) begin
        if (debt != DEBT_MAX) debt <= debt + 1'b1;
      end else if (aref_now && !tick) begin
        if (debt != '0) debt <= debt - 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= S_IDLE;
      cmd      <= CMD_NOP;
      Sa       <= '0;
      ref_req  <= 1'b0;
      ref_busy <= 1'b0;
      ref_done <= 1'b0;
      wait_cnt <= '0;
      n_ref    <= '0;
      issued   <= '0;
    end else begin
      ref_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ref_en && debt != '0) begin
            state   <= S_REQ;
            ref_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (!ref_en) begin
            state   <= S_IDLE;
            ref_req <= 1'b0;
          end else if (ref_ack) begin
            state    <= S_PRE;
            ref_req  <= 1'b0;
            ref_busy <= 1'b1;
            n_ref    <= burst_n;
            issued   <= '0;
            cmd      <= CMD_PRE;
            Sa       <= SA_PALL;
          end
        end
        S_PRE: begin
          if (T_RP > 1) begin
            state    <= S_TRP;
            wait_cnt <= CW'(T_RP - 2);
            cmd      <= CMD_NOP;
          end else begin
            state  <= S_AREF;
            issued <= issued + 1'b1;
            cmd    <= CMD_AREF;
          end
        end
        S_TRP: begin
          if (wait_cnt == '0) begin
            state  <= S_AREF;
            issued <= issued + 1'b1;
            cmd    <= CMD_AREF;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_AREF: begin
          if (T_RFC > 1) begin
            state    <= S_TRFC;
            wait_cnt <= CW'(T_RFC - 2);
            cmd      <= CMD_NOP;
          end else if (more) begin
            issued <= issued + 1'b1;
            cmd    <= CMD_AREF;
          end else begin
            state    <= S_DONE;
            ref_done <= 1'b1;
            cmd      <= CMD_NOP;
          end
        end
        S_TRFC: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else if (more) begin
            state  <= S_AREF;
            issued <= issued + 1'b1;
            cmd    <= CMD_AREF;
          end else begin
            state    <= S_DONE;
            ref_done <= 1'b1;
          end
        end
        S_DONE: begin
          // Remaining debt re-requests straight away rather than idling a cycle.
          ref_busy <= 1'b0;
          if (ref_en && debt != '0) begin
            state   <= S_REQ;
            ref_req <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_refresh_ctrl.sv
// tb/tb_sdram_refresh_ctrl.sv - self-checking bench for sdram_refresh_ctrl
// Bus commands are scoreboarded against expected {cmd, Sa, cycle}; flags are checked inline.
module tb_sdram_refresh_ctrl;

  localparam int ASIZE = 12, T_REFI = 20, T_RP = 2, T_RFC = 4;
  localparam int REF_BURST = 2, MAX_DEBT = 8, URGENT_TH = 6;
  localparam logic [3:0]  NOP = 4'b0111, PRE = 4'b0010, AREF = 4'b0001;
  localparam logic [11:0] SA_PALL = 12'h400;

  logic Clk = 1'b0, Rst_n = 1'b0, ref_en = 1'b0, ref_ack = 1'b0;
  logic ref_req, ref_urgent, ref_busy, ref_done, ref_ovf;
  logic [3:0] debt;
  logic Cs_n, Ras_n, Cas_n, We_n;
  logic [ASIZE-1:0] Sa;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [11:0] sa;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0, errors = 0;
  int   s, pre, aref, done;

  sdram_refresh_ctrl #(
    .ASIZE(ASIZE), .T_REFI(T_REFI), .T_RP(T_RP), .T_RFC(T_RFC),
    .REF_BURST(REF_BURST), .MAX_DEBT(MAX_DEBT), .URGENT_TH(URGENT_TH)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ref_en(ref_en), .ref_ack(ref_ack),
    .ref_req(ref_req), .ref_urgent(ref_urgent), .ref_busy(ref_busy),
    .ref_done(ref_done), .ref_ovf(ref_ovf), .debt(debt),
    .Cs_n(Cs_n), .Ras_n(Ras_n), .Cas_n(Cas_n), .We_n(We_n), .Sa(Sa)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Any non-NOP command must match the next expected bus event exactly.
  always @(negedge Clk) begin
    if ({Cs_n, Ras_n, Cas_n, We_n} !== NOP) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cmd cyc=%0d got cmd=%b sa=%h", cyc, {Cs_n, Ras_n, Cas_n, We_n}, Sa);
      end else begin
        e = exp_q.pop_front();
        if ({Cs_n, Ras_n, Cas_n, We_n, Sa, cyc} !== {e.cmd, e.sa, e.cyc}) begin
          errors++;
          $display("FAIL bus_cmd got cmd=%b sa=%h cyc=%0d expected cmd=%b sa=%h cyc=%0d",
                   {Cs_n, Ras_n, Cas_n, We_n}, Sa, cyc, e.cmd, e.sa, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic push(input logic [3:0] c, input logic [11:0] a, input int t);
    exp_t x;
    x.cmd = c; x.sa = a; x.cyc = t;
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0; ref_en = 1'b0; ref_ack = 1'b0;
    step(); step();
    Rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({Cs_n, Ras_n, Cas_n, We_n} !== NOP || Sa !== '0) begin
      errors++; $display("FAIL reset_bus got cmd=%b sa=%h expected 0111/000", {Cs_n, Ras_n, Cas_n, We_n}, Sa);
    end
    checks++;
    if ({ref_req, ref_urgent, ref_busy, ref_done, ref_ovf} !== 5'b0 || debt !== 4'd0) begin
      errors++; $display("FAIL reset_flags got flags=%b debt=%0d expected 00000/0",
                         {ref_req, ref_urgent, ref_busy, ref_done, ref_ovf}, debt);
    end
  endtask

  task automatic test_single();
    do_reset();
    s = cyc; ref_en = 1'b1; ref_ack = 1'b1;
    pre = s + T_REFI + 2;
    push(PRE, SA_PALL, pre);
    push(AREF, SA_PALL, pre + T_RP);
    wait_until(s + T_REFI - 1);
    checks++;
    if (debt !== 4'd0 || ref_req !== 1'b0) begin
      errors++; $display("FAIL single_pretick got debt=%0d req=%b expected 0/0", debt, ref_req);
    end
    wait_until(s + T_REFI);
    checks++;
    if (debt !== 4'd1) begin errors++; $display("FAIL single_tick_debt got=%0d expected=1", debt); end
    wait_until(s + T_REFI + 1);
    checks++;
    if (ref_req !== 1'b1) begin errors++; $display("FAIL single_req got=%b expected=1", ref_req); end
    wait_until(pre);
    checks++;
    if (ref_busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b expected=1", ref_busy); end
    wait_until(pre + T_RP + 1);
    checks++;
    if (debt !== 4'd0) begin errors++; $display("FAIL single_debt_after got=%0d expected=0", debt); end
    wait_until(pre + T_RP + T_RFC);
    checks++;
    if (ref_done !== 1'b1 || ref_busy !== 1'b1) begin
      errors++; $display("FAIL single_done got done=%b busy=%b expected 1/1", ref_done, ref_busy);
    end
    step();
    checks++;
    if (ref_done !== 1'b0 || ref_busy !== 1'b0 || ref_req !== 1'b0) begin
      errors++; $display("FAIL single_release got done=%b busy=%b req=%b expected 0/0/0", ref_done, ref_busy, ref_req);
    end
    ref_en = 1'b0; ref_ack = 1'b0;
  endtask

  task automatic test_burst();
    do_reset();
    s = cyc; ref_en = 1'b1; ref_ack = 1'b0;
    wait_until(s + 3 * T_REFI);
    checks++;
    if (debt !== 4'd3 || ref_req !== 1'b1 || ref_busy !== 1'b0) begin
      errors++; $display("FAIL burst_wait got debt=%0d req=%b busy=%b expected 3/1/0", debt, ref_req, ref_busy);
    end
    ref_ack = 1'b1;
    pre = s + 3 * T_REFI + 1;
    push(PRE, SA_PALL, pre);
    push(AREF, SA_PALL, pre + T_RP);
    push(AREF, SA_PALL, pre + T_RP + T_RFC);
    wait_until(pre + T_RP + 1);
    checks++;
    if (debt !== 4'd2) begin errors++; $display("FAIL burst_debt2 got=%0d expected=2", debt); end
    wait_until(pre + T_RP + T_RFC + 1);
    checks++;
    if (debt !== 4'd1) begin errors++; $display("FAIL burst_debt1 got=%0d expected=1", debt); end
    done = pre + T_RP + 2 * T_RFC;
    wait_until(done);
    checks++;
    if (ref_done !== 1'b1) begin errors++; $display("FAIL burst_done got=%b expected=1", ref_done); end
    step();
    checks++;
    if (ref_req !== 1'b1 || ref_done !== 1'b0) begin
      errors++; $display("FAIL burst_rereq got req=%b done=%b expected 1/0", ref_req, ref_done);
    end
    ref_en = 1'b0; ref_ack = 1'b0;
    step();
    checks++;
    if (ref_req !== 1'b0 || debt !== 4'd0) begin
      errors++; $display("FAIL burst_en_off got req=%b debt=%0d expected 0/0", ref_req, debt);
    end
  endtask

  task automatic test_urgent_ovf();
    do_reset();
    s = cyc; ref_en = 1'b1; ref_ack = 1'b0;
    wait_until(s + (URGENT_TH - 1) * T_REFI);
    checks++;
    if (debt !== 4'(URGENT_TH - 1) || ref_urgent !== 1'b0) begin
      errors++; $display("FAIL urgent_below got debt=%0d urgent=%b expected %0d/0", debt, ref_urgent, URGENT_TH - 1);
    end
    wait_until(s + URGENT_TH * T_REFI);
    checks++;
    if (debt !== 4'(URGENT_TH) || ref_urgent !== 1'b1) begin
      errors++; $display("FAIL urgent_at got debt=%0d urgent=%b expected %0d/1", debt, ref_urgent, URGENT_TH);
    end
    wait_until(s + MAX_DEBT * T_REFI);
    checks++;
    if (debt !== 4'(MAX_DEBT) || ref_ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_at_max got debt=%0d ovf=%b expected %0d/0", debt, ref_ovf, MAX_DEBT);
    end
    wait_until(s + (MAX_DEBT + 1) * T_REFI);
    checks++;
    if (debt !== 4'(MAX_DEBT) || ref_ovf !== 1'b1 || ref_urgent !== 1'b1) begin
      errors++; $display("FAIL ovf_set got debt=%0d ovf=%b urgent=%b expected %0d/1/1", debt, ref_ovf, ref_urgent, MAX_DEBT);
    end
    ref_en = 1'b0;
    step();
    checks++;
    if (debt !== 4'd0 || ref_ovf !== 1'b1 || ref_urgent !== 1'b0 || ref_req !== 1'b0) begin
      errors++; $display("FAIL ovf_sticky got debt=%0d ovf=%b urgent=%b req=%b expected 0/1/0/0",
                         debt, ref_ovf, ref_urgent, ref_req);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    checks++;
    if (ref_ovf !== 1'b0) begin errors++; $display("FAIL ovf_reset_clear got=%b expected=0", ref_ovf); end
    s = cyc; ref_en = 1'b1; ref_ack = 1'b0;
    aref = s + 2 * T_REFI - 1;
    pre = aref - T_RP;
    push(PRE, SA_PALL, pre);
    push(AREF, SA_PALL, aref);
    wait_until(pre - 1);
    ref_ack = 1'b1;
    wait_until(aref);
    checks++;
    if (debt !== 4'd1) begin errors++; $display("FAIL simul_before got=%0d expected=1", debt); end
    wait_until(aref + 1);
    checks++;
    if (debt !== 4'd1) begin errors++; $display("FAIL simul_tick_aref got=%0d expected=1", debt); end
    ref_ack = 1'b0;
    done = pre + T_RP + T_RFC;
    wait_until(done);
    checks++;
    if (ref_done !== 1'b1 || debt !== 4'd1) begin
      errors++; $display("FAIL simul_done got done=%b debt=%0d expected 1/1", ref_done, debt);
    end
    step();
    checks++;
    if (ref_req !== 1'b1) begin errors++; $display("FAIL simul_rereq got=%b expected=1", ref_req); end
    ref_en = 1'b0;
    step();
  endtask

  task automatic test_en_drop();
    do_reset();
    s = cyc; ref_en = 1'b1; ref_ack = 1'b0;
    wait_until(s + 2 * T_REFI);
    checks++;
    if (debt !== 4'd2) begin errors++; $display("FAIL endrop_debt2 got=%0d expected=2", debt); end
    ref_ack = 1'b1;
    pre = s + 2 * T_REFI + 1;
    push(PRE, SA_PALL, pre);
    push(AREF, SA_PALL, pre + T_RP);
    push(AREF, SA_PALL, pre + T_RP + T_RFC);
    wait_until(pre + T_RP + 1);
    checks++;
    if (debt !== 4'd1) begin errors++; $display("FAIL endrop_mid got=%0d expected=1", debt); end
    ref_en = 1'b0;
    step();
    checks++;
    if (debt !== 4'd0 || ref_busy !== 1'b1) begin
      errors++; $display("FAIL endrop_clear got debt=%0d busy=%b expected 0/1", debt, ref_busy);
    end
    done = pre + T_RP + 2 * T_RFC;
    wait_until(done);
    checks++;
    if (ref_done !== 1'b1 || debt !== 4'd0) begin
      errors++; $display("FAIL endrop_done got done=%b debt=%0d expected 1/0", ref_done, debt);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (ref_req !== 1'b0 || ref_busy !== 1'b0) begin
        errors++; $display("FAIL endrop_quiet i=%0d got req=%b busy=%b expected 0/0", i, ref_req, ref_busy);
      end
    end
    ref_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    s = cyc; ref_en = 1'b1; ref_ack = 1'b1;
    pre = s + T_REFI + 2;
    push(PRE, SA_PALL, pre);
    wait_until(pre + 1);
    checks++;
    if (ref_busy !== 1'b1 || {Cs_n, Ras_n, Cas_n, We_n} !== NOP) begin
      errors++; $display("FAIL rstmid_trp got busy=%b cmd=%b expected 1/0111", ref_busy, {Cs_n, Ras_n, Cas_n, We_n});
    end
    Rst_n = 1'b0;
    #1;
    checks++;
    if ({Cs_n, Ras_n, Cas_n, We_n} !== NOP || Sa !== '0) begin
      errors++; $display("FAIL rstmid_bus got cmd=%b sa=%h expected 0111/000", {Cs_n, Ras_n, Cas_n, We_n}, Sa);
    end
    checks++;
    if ({ref_req, ref_urgent, ref_busy, ref_done, ref_ovf} !== 5'b0 || debt !== 4'd0) begin
      errors++; $display("FAIL rstmid_flags got flags=%b debt=%0d expected 00000/0",
                         {ref_req, ref_urgent, ref_busy, ref_done, ref_ovf}, debt);
    end
    ref_en = 1'b0; ref_ack = 1'b0;
    step();
    Rst_n = 1'b1;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_urgent_ovf();
    test_simultaneous();
    test_en_drop();
    test_reset_mid();
    step(); step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL missing_cmds got pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
